tl_intersection_ctrl: RTL

Phase sequencer for a two-road intersection: a major north–south road and a minor east–west road, with a pedestrian crossing. It drives two three-lamp traffic-light heads and a walk signal. It rests in north–south green and serves east–west vehicle demand and latched pedestrian requests through yellow and all-red clearance phases. It sits above the single-light `TL` block and replaces free-running cycling with demand-driven scheduling.

---
 rtl/tl_intersection_ctrl_pkg.sv | 20 ++
 rtl/tl_phase_timer.sv | 22 ++
 rtl/tl_intersection_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/tl_intersection_ctrl_pkg.sv
// Shared definitions for the intersection phase sequencer:
// phase encodings and the three-lamp head constants.
package tl_intersection_ctrl_pkg;

    typedef enum logic [2:0] {
        NS_G = 3'd0,
        NS_Y = 3'd1,
        AR1  = 3'd2,
        WALK = 3'd3,
        EW_G = 3'd4,
        EW_Y = 3'd5,
        AR2  = 3'd6
    } phase_t;

    // Lamp heads are {red, yellow, green}
    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

endpackage

// File: rtl/tl_phase_timer.sv
// Phase cycle counter: synchronous clear on phase change, saturates at
// all-ones so an indefinitely held phase cannot wrap back to zero.
module tl_phase_timer #(
    parameter int CW = 5
) (
    input  logic          clk,
    input  logic          res,
    input  logic          clr,
    output logic [CW-1:0] cnt
);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (cnt != '1) begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/tl_intersection_ctrl.sv
// Demand-driven phase sequencer for a major NS road, a minor EW road and
// a pedestrian crossing. Rests in NS green; lamps decode from state only.
//
// state | meaning
// ------+-------------------------------------------------
// NS_G  | NS green, EW red; rest phase, waits for demand
// NS_Y  | NS yellow, EW red
// AR1   | all red, clearing NS traffic
// WALK  | all red, walk lamp lit
// EW_G  | EW green, NS red
// EW_Y  | EW yellow, NS red
// AR2   | all red, clearing EW traffic / crossing
module tl_intersection_ctrl
    import tl_intersection_ctrl_pkg::*;
#(
    parameter int T_GREEN_MIN = 8,
    parameter int T_GREEN_MAX = 20,
    parameter int T_YELLOW    = 3,
    parameter int T_ALLRED    = 1,
    parameter int T_WALK      = 6,
    parameter int CW          = 5
) (
    input  logic       clk,
    input  logic       res,
    input  logic       ew_req,
    input  logic       ped_req,
    output logic [2:0] ns_light,
    output logic [2:0] ew_light,
    output logic       walk,
    output logic       ped_pend,
    output logic [2:0] state
);

    localparam logic [CW-1:0] GMIN_TC = CW'(T_GREEN_MIN - 1);
    localparam logic [CW-1:0] GMAX_TC = CW'(T_GREEN_MAX - 1);
    localparam logic [CW-1:0] YEL_TC  = CW'(T_YELLOW - 1);
    localparam logic [CW-1:0] AR_TC   = CW'(T_ALLRED - 1);
    localparam logic [CW-1:0] WALK_TC = CW'(T_WALK - 1);

    phase_t        state_q;
    phase_t        state_d;
    logic [CW-1:0] cnt;
    logic          phase_chg;
    logic          enter_walk;

    assign phase_chg  = (state_d != state_q);
    assign enter_walk = (state_d == WALK) && (state_q != WALK);
    assign state      = state_q;

    tl_phase_timer #(.CW(CW)) u_timer (
        .clk (clk),
        .res (res),
        .clr (phase_chg),
        .cnt (cnt)
    );

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= NS_G;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            NS_G: if (cnt >= GMIN_TC && (ew_req || ped_pend)) state_d = NS_Y;
            NS_Y: if (cnt == YEL_TC) state_d = AR1;
            AR1:  if (cnt == AR_TC) state_d = ped_pend ? WALK : EW_G;
            WALK: if (cnt == WALK_TC) state_d = ew_req ? EW_G : AR2;
            EW_G: if ((cnt >= GMIN_TC && !ew_req) || cnt == GMAX_TC) state_d = EW_Y;
            EW_Y: if (cnt == YEL_TC) state_d = AR2;
            AR2:  if (cnt == AR_TC) state_d = NS_G;
            default: state_d = NS_G;
        endcase
    end

    // Clearing on WALK entry takes priority over a request on that same edge
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            ped_pend <= 1'b0;
        end else if (enter_walk) begin
            ped_pend <= 1'b0;
        end else if (ped_req && state_q != WALK) begin
            ped_pend <= 1'b1;
        end
    end

    always_comb begin
        ns_light = LAMP_RED;
        ew_light = LAMP_RED;
        walk     = 1'b0;
        case (state_q)
            NS_G:    ns_light = LAMP_GRN;
            NS_Y:    ns_light = LAMP_YEL;
            EW_G:    ew_light = LAMP_GRN;
            EW_Y:    ew_light = LAMP_YEL;
            WALK:    walk     = 1'b1;
            default: ;
        endcase
    end

endmodule
